// File: rtl/mem_arb.sv
// mem_arb: shares one SDRAM burst-read channel between N requesters.
// Requester 0 (display) has fixed top priority; requesters 1..N-1 rotate
// round-robin. Each accepted burst pushes its owner id into a tag FIFO,
// and returned words are steered back to the owner at the FIFO head.
module mem_arb #(
    parameter int AN    = 24,   // address width
    parameter int DN    = 16,   // data width
    parameter int N     = 4,    // requesters, 2..8, index 0 is the display
    parameter int BURST = 8,    // words per burst, power of 2, >= 2
    parameter int DEPTH = 4     // outstanding bursts, power of 2
) (
    input  logic            clkSYS,
    input  logic            n_reset,
    input  logic [N-1:0]    req,
    input  logic [N*AN-1:0] req_addr,
    output logic [N-1:0]    req_ack,
    output logic [N-1:0]    data_valid,
    output logic [DN-1:0]   data,
    output logic            mem_req,
    output logic [AN-1:0]   mem_addr,
    input  logic            mem_ack,
    input  logic [DN-1:0]   mem_data,
    input  logic            mem_valid,
    output logic            err
);

    localparam int GW = $clog2(N);                        // requester id width
    localparam int BW = $clog2(BURST);                    // beat counter width
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;  // FIFO pointer width
    localparam int CW = $clog2(DEPTH + 1);                // FIFO occupancy width

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [AN-1:0]   addr_q, addr_d;

    logic [GW-1:0]   tag_mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [BW-1:0]   beat_q;
    logic            err_q;

    logic            fifo_full, fifo_empty;
    logic            push, pop, beat_en, last_beat;
    logic [GW-1:0]   winner, head;

    // Winner for this IDLE cycle: requester 0 outright, otherwise the first
    // active requester at or after ptr among 1..N-1, wrapping past N-1 to 1.
    function automatic logic [GW-1:0] rr_pick(input logic [N-1:0] r,
                                              input logic [GW-1:0] ptr);
        logic found;
        int   idx;
        rr_pick = '0;
        found   = 1'b0;
        if (!r[0]) begin
            for (int k = 0; k < N - 1; k++) begin
                idx = int'(ptr) + k;
                if (idx >= N) idx = idx - (N - 1);
                if (!found && r[idx]) begin
                    found   = 1'b1;
                    rr_pick = GW'(idx);
                end
            end
        end
    endfunction

    assign winner     = rr_pick(req, rr_ptr_q);
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head       = tag_mem[rd_ptr_q];

    assign mem_addr   = addr_q;
    assign data       = mem_data;
    assign err        = err_q;

    // Grant FSM: latch a winner in IDLE, present it in ISSUE until accepted.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        addr_d   = addr_q;
        mem_req  = 1'b0;
        req_ack  = '0;
        push     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if ((|req) && !fifo_full) begin
                    grant_d = winner;
                    addr_d  = req_addr[int'(winner)*AN +: AN];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // The grant is held until the controller takes it, even if
                // the requester lets go of req in the meantime.
                mem_req = 1'b1;
                if (mem_ack) begin
                    req_ack = N'(1) << grant_q;
                    push    = 1'b1;
                    if (grant_q != '0) begin
                        rr_ptr_d = (grant_q == GW'(N - 1)) ? GW'(1)
                                                           : grant_q + GW'(1);
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant FSM state, granted id, burst address and rotation pointer.
    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= GW'(1);
            addr_q   <= '0;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop in
            // the design samples the same pre-edge values.
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            addr_q   <= addr_d;
        end
    end

    // Return-path steering: words belong to the burst at the FIFO head.
    always_comb begin
        beat_en    = mem_valid && !fifo_empty;
        last_beat  = (beat_q == BW'(BURST - 1));
        pop        = beat_en && last_beat;
        data_valid = beat_en ? (N'(1) << head) : '0;
    end

    // Tag storage: written on each accepted burst.
    always_ff @(posedge clkSYS) begin
        // NOTE: tag storage has no reset; the pointers and occupancy decide
        // which entries are live, so stale contents are never observed.
        if (push) tag_mem[wr_ptr_q] <= grant_q;
    end

    // Tag FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    // Beat counter within the head burst and the sticky orphan-data flag.
    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            beat_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (beat_en) beat_q <= beat_q + BW'(1);
            if (mem_valid && fifo_empty) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed bench for mem_arb. Expected grant ids are queued as
// requests are raised; each ack pops one and queues its owner, and returned
// beats are checked against the owner at the front of that queue.
module tb_mem_arb;

    localparam int AN    = 24;
    localparam int DN    = 16;
    localparam int N     = 4;
    localparam int BURST = 8;
    localparam int DEPTH = 4;

    logic            clkSYS = 1'b0;
    logic            n_reset = 1'b0;
    logic [N-1:0]    req;
    logic [N*AN-1:0] req_addr;
    logic [N-1:0]    req_ack;
    logic [N-1:0]    data_valid;
    logic [DN-1:0]   data;
    logic            mem_req;
    logic [AN-1:0]   mem_addr;
    logic            mem_ack;
    logic [DN-1:0]   mem_data;
    logic            mem_valid;
    logic            err;

    always #5 clkSYS = ~clkSYS;

    mem_arb #(.AN(AN), .DN(DN), .N(N), .BURST(BURST), .DEPTH(DEPTH)) dut (
        .clkSYS     (clkSYS),
        .n_reset    (n_reset),
        .req        (req),
        .req_addr   (req_addr),
        .req_ack    (req_ack),
        .data_valid (data_valid),
        .data       (data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .mem_valid  (mem_valid),
        .err        (err)
    );

    int            checks    = 0;
    int            failures  = 0;
    int            ack_count = 0;
    int            cyc_count = 0;
    int            tb_beat   = 0;
    logic          exp_err   = 1'b0;
    logic          auto_ret  = 1'b0;
    int            exp_grant[$];
    int            exp_owner[$];
    logic [AN-1:0] addr_tab [N];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle scoreboard: err, data steering, then grants.
    task automatic monitor();
        int g;
        int done;
        check("err", err, exp_err);
        if (mem_valid) begin
            check("data_bcast", data, mem_data);
            if (exp_owner.size() == 0) begin
                check("dv_orphan", data_valid, 0);
                exp_err = 1'b1;
            end else begin
                check("dv_owner", data_valid, 64'(1) << exp_owner[0]);
                tb_beat++;
                if (tb_beat == BURST) begin
                    tb_beat = 0;
                    done = exp_owner.pop_front();
                end
            end
        end else begin
            check("dv_idle", data_valid, 0);
        end
        if (req_ack !== '0) begin
            if (exp_grant.size() == 0) begin
                check("ack_spurious", req_ack, 0);
            end else begin
                g = exp_grant.pop_front();
                check("ack_onehot", req_ack, 64'(1) << g);
                check("ack_addr", mem_addr, addr_tab[g]);
                check("ack_mem_req", mem_req, 1);
                exp_owner.push_back(g);
                ack_count++;
            end
        end
    endtask

    // One clock: entered and left at posedge+1, outputs sampled at posedge+3.
    task automatic cyc();
        if (auto_ret) begin
            mem_valid = (exp_owner.size() != 0);
            mem_data  = DN'($urandom);
        end
        #2;
        monitor();
        cyc_count++;
        @(posedge clkSYS);
        #1;
    endtask

    task automatic wait_acks(input int target);
        int budget;
        budget = 300;
        while (ack_count < target && budget > 0) begin
            cyc();
            budget--;
        end
        check("ack_timeout", ack_count >= target, 1);
    endtask

    task automatic drain();
        int budget;
        budget = 400;
        auto_ret = 1'b1;
        while (exp_owner.size() != 0 && budget > 0) begin
            cyc();
            budget--;
        end
        check("drain_timeout", exp_owner.size(), 0);
        auto_ret  = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic beats(input int n);
        mem_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            mem_data = DN'($urandom);
            cyc();
        end
        mem_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int t0;
        addr_tab[0] = 24'h000100;
        addr_tab[1] = 24'h012340;
        addr_tab[2] = 24'h0ABC00;
        addr_tab[3] = 24'hFFFF00;
        for (int i = 0; i < N; i++) req_addr[i*AN +: AN] = addr_tab[i];
        req       = '0;
        mem_ack   = 1'b1;
        mem_valid = 1'b1;
        mem_data  = '0;

        // Reset values, with live inputs that must not leak through.
        repeat (2) @(posedge clkSYS);
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_req_ack", req_ack, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_err", err, 0);
        mem_valid = 1'b0;
        n_reset   = 1'b1;

        // Single display request: 1-cycle arbitration, ack, 8 beats.
        req = 4'b0001;
        exp_grant.push_back(0);
        #1;
        check("s1_idle_mem_req", mem_req, 0);
        cyc();
        #1;
        check("s1_issue_mem_req", mem_req, 1);
        check("s1_issue_addr", mem_addr, 24'h000100);
        cyc();
        req = '0;
        #1;
        check("s1_back_idle", mem_req, 0);
        beats(BURST);

        // Lone beat with nothing outstanding: dropped, err sticks.
        beats(1);
        repeat (4) cyc();
        n_reset = 1'b0;
        #1;
        check("s5_rst_err", err, 0);
        check("s5_rst_mem_req", mem_req, 0);
        exp_err = 1'b0;
        @(posedge clkSYS);
        #1;
        n_reset = 1'b1;

        // Rotation 1,2,3,1,2 with req held; display cuts in, then rotation resumes.
        req      = 4'b1110;
        auto_ret = 1'b1;
        base     = ack_count;
        exp_grant.push_back(1);
        exp_grant.push_back(2);
        exp_grant.push_back(3);
        exp_grant.push_back(1);
        exp_grant.push_back(2);
        wait_acks(base + 1);
        t0 = cyc_count;
        wait_acks(base + 2);
        check("s2_ack_spacing", cyc_count - t0, 2);
        wait_acks(base + 5);
        req[0] = 1'b1;
        exp_grant.push_back(0);
        wait_acks(base + 6);
        req[0] = 1'b0;
        exp_grant.push_back(3);
        exp_grant.push_back(1);
        wait_acks(base + 8);
        req = '0;
        drain();

        // Data withheld: exactly DEPTH grants, then mem_req stays low.
        req  = 4'b1110;
        base = ack_count;
        exp_grant.push_back(2);
        exp_grant.push_back(3);
        exp_grant.push_back(1);
        exp_grant.push_back(2);
        wait_acks(base + 4);
        repeat (10) begin
            #1;
            check("s3_full_no_mem_req", mem_req, 0);
            cyc();
        end
        exp_grant.push_back(3);
        beats(BURST);
        wait_acks(base + 5);
        req = '0;
        drain();

        // Last beat of A coincides with ack of C; next beat goes to B.
        base = ack_count;
        req  = 4'b0010;
        exp_grant.push_back(1);
        wait_acks(base + 1);
        req = 4'b0100;
        exp_grant.push_back(2);
        wait_acks(base + 2);
        req = '0;
        beats(BURST - 2);
        mem_valid = 1'b1;
        mem_data  = DN'($urandom);
        req       = 4'b1000;
        exp_grant.push_back(3);
        cyc();
        mem_data = DN'($urandom);
        #1;
        check("s4_pushpop_ack", req_ack, 4'b1000);
        check("s4_pushpop_dv", data_valid, 4'b0010);
        cyc();
        req = '0;
        mem_data = DN'($urandom);
        #1;
        check("s4_next_owner", data_valid, 4'b0100);
        drain();

        // Reset while in ISSUE with two bursts outstanding, mid-burst.
        base = ack_count;
        req  = 4'b0010;
        exp_grant.push_back(1);
        wait_acks(base + 1);
        req = 4'b0100;
        exp_grant.push_back(2);
        wait_acks(base + 2);
        mem_ack = 1'b0;
        req     = 4'b1000;
        beats(3);
        mem_valid = 1'b1;
        #1;
        check("s6_in_issue", mem_req, 1);
        mem_ack = 1'b1;
        n_reset = 1'b0;
        #1;
        check("s6_rst_mem_req", mem_req, 0);
        check("s6_rst_req_ack", req_ack, 0);
        check("s6_rst_dv", data_valid, 0);
        check("s6_rst_mem_addr", mem_addr, 0);
        check("s6_rst_err", err, 0);
        exp_grant.delete();
        exp_owner.delete();
        tb_beat   = 0;
        exp_err   = 1'b0;
        mem_valid = 1'b0;
        req       = '0;
        repeat (2) @(posedge clkSYS);
        #1;
        n_reset = 1'b1;
        // Pointer back at 1: with 2 and 3 requesting, 2 wins.
        req  = 4'b1100;
        base = ack_count;
        exp_grant.push_back(2);
        wait_acks(base + 1);
        req = '0;
        beats(BURST);
        // A full burst from beat 0 leaves nothing outstanding.
        beats(1);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
